// File: rtl/pipe_skid_reg_pkg.sv
// Shared types and constants for the handshaked pipeline skid register.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BUSY  = 2'b01,
    FULL  = 2'b10
  } skid_state_t;

  localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/pipe_en_reg.sv
// N-bit storage register with async active-high reset, synchronous clear and load enable.
module pipe_en_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load so a squash never lets a same-cycle write survive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= {W{1'b0}};
    end else if (clr) begin
      q <= {W{1'b0}};
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages; in_ready is decoded from registered state.
// Optional backpressure counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  skid_state_t state_r;
  skid_state_t next_state_s;
  logic        in_fire_s;
  logic        out_fire_s;
  logic        main_en_s;
  logic        main_from_skid_s;
  logic        skid_en_s;
  logic [N-1:0] main_d_s;
  logic [N-1:0] main_q;
  logic [N-1:0] skid_q;

  assign out_valid  = (state_r != EMPTY);
  assign in_ready   = (state_r != FULL);
  assign out_data   = main_q;
  assign in_fire_s  = in_valid & in_ready;
  assign out_fire_s = out_valid & out_ready;
  assign main_d_s   = main_from_skid_s ? skid_q : in_data;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state and storage write enables.
  always_comb begin
    next_state_s     = state_r;
    main_en_s        = 1'b0;
    main_from_skid_s = 1'b0;
    skid_en_s        = 1'b0;
    case (state_r)
      EMPTY: begin
        if (in_fire_s) begin
          main_en_s    = 1'b1;
          next_state_s = BUSY;
        end else begin
          next_state_s = EMPTY;
        end
      end
      BUSY: begin
        if (in_fire_s && out_fire_s) begin
          main_en_s    = 1'b1;
          next_state_s = BUSY;
        end else if (in_fire_s) begin
          skid_en_s    = 1'b1;
          next_state_s = FULL;
        end else if (out_fire_s) begin
          next_state_s = EMPTY;
        end else begin
          next_state_s = BUSY;
        end
      end
      FULL: begin
        if (out_fire_s) begin
          main_en_s        = 1'b1;
          main_from_skid_s = 1'b1;
          next_state_s     = BUSY;
        end else begin
          next_state_s = FULL;
        end
      end
      default: begin
        next_state_s = EMPTY;
      end
    endcase
    // Squash overrides every transition; the registers clear themselves via clr.
    if (flush) begin
      next_state_s = EMPTY;
    end else begin
      next_state_s = next_state_s;
    end
  end

  pipe_en_reg #(.W(N)) u_main (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (main_en_s),
    .d   (main_d_s),
    .q   (main_q)
  );

  pipe_en_reg #(.W(N)) u_skid (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (skid_en_s),
    .d   (in_data),
    .q   (skid_q)
  );

`ifdef PIPE_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_r;

  // Saturating count of producer backpressure cycles; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {STALL_CNT_W{1'b0}};
    end else if (in_valid && !in_ready && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed vector table, corner sequences, random vs queue model.
module tb_pipe_skid_reg;

  localparam int N = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
`ifdef PIPE_STALL_CNT_EN
  logic [15:0]  stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  pipe_skid_reg #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic cyc(input logic iv, input logic [N-1:0] d, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         iv;
    logic [N-1:0] d;
    logic         ordy;
    logic         fl;
    logic         e_ov;
    logic         e_ir;
    logic [N-1:0] e_od;
  } vec_t;

  vec_t vecs[$];
  logic [N-1:0] model_q[$];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_data",  out_data,           32'd0);
    @(posedge clk); #1;

    // Expected values are the outputs visible after the edge that applies each row.
    vecs.push_back('{1'b1, 32'd1,     1'b1, 1'b0, 1'b1, 1'b1, 32'd1});
    vecs.push_back('{1'b1, 32'd2,     1'b1, 1'b0, 1'b1, 1'b1, 32'd2});
    vecs.push_back('{1'b1, 32'd3,     1'b1, 1'b0, 1'b1, 1'b1, 32'd3});
    vecs.push_back('{1'b1, 32'd4,     1'b1, 1'b0, 1'b1, 1'b1, 32'd4});
    vecs.push_back('{1'b0, 32'd0,     1'b1, 1'b0, 1'b0, 1'b1, 32'd4});
    vecs.push_back('{1'b1, 32'hA1,    1'b0, 1'b0, 1'b1, 1'b1, 32'hA1});
    vecs.push_back('{1'b1, 32'hA2,    1'b0, 1'b0, 1'b1, 1'b0, 32'hA1});
    vecs.push_back('{1'b1, 32'h99,    1'b0, 1'b0, 1'b1, 1'b0, 32'hA1});
    vecs.push_back('{1'b0, 32'd0,     1'b1, 1'b0, 1'b1, 1'b1, 32'hA2});
    vecs.push_back('{1'b0, 32'd0,     1'b1, 1'b0, 1'b0, 1'b1, 32'hA2});
    vecs.push_back('{1'b1, 32'd5,     1'b0, 1'b0, 1'b1, 1'b1, 32'd5});
    vecs.push_back('{1'b1, 32'd6,     1'b1, 1'b0, 1'b1, 1'b1, 32'd6});
    vecs.push_back('{1'b1, 32'd8,     1'b0, 1'b0, 1'b1, 1'b0, 32'd6});
    vecs.push_back('{1'b1, 32'd7,     1'b0, 1'b1, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 32'd0,     1'b1, 1'b0, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b1, 32'd9,     1'b0, 1'b1, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b0, 32'd0,     1'b0, 1'b0, 1'b0, 1'b1, 32'd0});
    vecs.push_back('{1'b1, 32'hB,     1'b0, 1'b0, 1'b1, 1'b1, 32'hB});
    vecs.push_back('{1'b0, 32'd0,     1'b1, 1'b1, 1'b0, 1'b1, 32'd0});

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
      chk($sformatf("vec%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("vec%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("vec%0d_out_data", i),  out_data,           vecs[i].e_od);
    end

    // Asynchronous reset between edges drops held data with no clock edge.
    cyc(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);
    chk("preload_data", out_data, 32'hDEAD_BEEF);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("async_rst_out_data",  out_data,           32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic against a capacity-2 FIFO model.
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    model_q.delete();
    for (int c = 0; c < 600; c++) begin
      logic m_ir;
      logic m_ov;
      logic fi;
      logic fo;
      m_ov = (model_q.size() > 0);
      m_ir = (model_q.size() < 2);
      chk("rand_out_valid", {31'd0, out_valid}, {31'd0, m_ov});
      chk("rand_in_ready",  {31'd0, in_ready},  {31'd0, m_ir});
      if (m_ov) chk("rand_out_data", out_data, model_q[0]);
      in_valid  = ($urandom_range(3, 0) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(2, 0) != 0);
      flush     = ($urandom_range(23, 0) == 0);
      fi = in_valid & m_ir;
      fo = m_ov & out_ready;
      @(posedge clk); #1;
      if (flush) begin
        model_q.delete();
      end else begin
        if (fo) void'(model_q.pop_front());
        if (fi) model_q.push_back(in_data);
      end
    end

`ifdef PIPE_STALL_CNT_EN
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    chk("stall_cnt_reset", {16'd0, stall_cnt}, 32'd0);
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    cyc(1'b1, 32'h22, 1'b0, 1'b0);
    for (int k = 0; k < 70000; k++) cyc(1'b1, 32'h33, 1'b0, 1'b0);
    chk("stall_cnt_sat", {16'd0, stall_cnt}, 32'h0000_FFFF);
    cyc(1'b1, 32'h33, 1'b0, 1'b1);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("stall_cnt_flush", {16'd0, stall_cnt}, 32'h0000_FFFF);
    rst = 1'b1; #1;
    chk("stall_cnt_rst", {16'd0, stall_cnt}, 32'd0);
    @(negedge clk); rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Handshaked pipeline register for inter-stage boundaries in the MIPS pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Consumer-side counterpart of the plain stage flop: it accepts a producer's valid/data and holds it until the downstream stage takes it.
- Two-entry skid buffer with registered in_ready, so the ready path is cut between stages.
- Full throughput (1 transfer/cycle), 1-cycle latency, synchronous flush for branch/exception squash.

Parameters:
- N, 32, payload width in bits.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous squash; discards all held entries.
- in_valid  in  1  producer has data.
- in_ready  out  1  block can accept; in_fire = in_valid & in_ready.
- in_data  in  N  producer payload.
- out_valid  out  1  main entry holds data.
- out_ready  in  1  consumer accepts; out_fire = out_valid & out_ready.
- out_data  out  N  main entry payload.
- stall_cnt  out  16  present only with PIPE_STALL_CNT_EN.

Behaviour:
- Storage: main_q[N], skid_q[N], state in {EMPTY, BUSY, FULL}.
- out_valid = (state != EMPTY). in_ready = (state != FULL). out_data = main_q. All outputs decode from registered state only; there are no combinational input-to-output paths.
- Reset (async, rst=1): state=EMPTY, main_q=0, skid_q=0, so out_valid=0, in_ready=1, out_data=0. Reset asserted mid-transfer drops all data immediately; no partial transfer survives.
- EMPTY:
  - in_fire: main_q<=in_data, go to BUSY.
- BUSY:
  - in_fire & out_fire: main_q<=in_data, stay BUSY.
  - in_fire & !out_fire: skid_q<=in_data, go to FULL.
  - !in_fire & out_fire: go to EMPTY.
  - Otherwise hold.
- FULL (in_ready=0, so no in_fire):
  - out_fire: main_q<=skid_q, go to BUSY.
  - Otherwise hold.
- Ordering: strict FIFO. Data is never duplicated, reordered or dropped except by flush or rst.
- Latency: data accepted at edge k appears on out_data/out_valid after edge k (visible in cycle k+1).
- Flush has priority over all transitions:
  - At the next edge, state=EMPTY and main_q=skid_q=0.
  - An in_fire in the flush cycle is discarded. in_ready may be 1 during flush; the producer sees a completed handshake and the data is squashed.
  - An out_fire in the flush cycle completes normally downstream, since the consumer already sampled it.
- out_valid, once asserted, must not drop without out_fire, flush or rst. out_data stays stable while out_valid & !out_ready.
- X-safety: in_data is ignored when in_valid=0. Nothing is written to storage without in_fire.

Optional Feature:
- Macro: PIPE_STALL_CNT_EN.
- Defined:
  - stall_cnt port exists: 16-bit saturating counter.
  - Increments each cycle with in_valid & !in_ready (backpressure cycle).
  - Saturates at 16'hFFFF; it does not wrap.
  - Cleared by rst only; flush does not clear it.
- Undefined: port, counter and its logic are absent.
- Core behaviour is identical in both builds.

Decomposition:
- Package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}.
  - localparam STALL_CNT_W = 16.
- One natural sub-module: pipe_en_reg, a parameterised N-bit register with async active-high reset, synchronous clear and load enable. Instantiated twice, once for main_q and once for skid_q.
- The state machine lives in the top module.

Test Plan:
- Reset mid-stream: load 32'hDEAD_BEEF, assert rst asynchronously between edges -> out_valid=0, in_ready=1, out_data=0 immediately, without waiting for a clock edge.
- Streaming: out_ready=1, send 1,2,3,4 on consecutive cycles -> out_data 1,2,3,4 one cycle later, in_ready stays 1, no bubbles.
- Backpressure: out_ready=0, send 8'hA1 then 8'hA2 -> state FULL, in_ready=0, out_data=A1. Raise out_ready -> A1 then A2 on consecutive cycles, then out_valid=0.
- Simultaneous in/out in BUSY: holding 5, in_data=6 with both fires -> out_data=6 next cycle, state BUSY, skid_q unused.
- Flush in FULL with in_valid=1, in_data=7 -> next cycle out_valid=0, in_ready=1, 7 never appears on the output.
- PIPE_STALL_CNT_EN build: hold FULL with in_valid=1 for 70000 cycles -> stall_cnt=16'hFFFF. flush -> value unchanged. rst -> 0.
